// File: rtl/score_keeper_if.sv
// ---------------------------------------------------------------------------
// score_keeper_if
//   Bundles the event pulses from the game-logic FSM and the committed score
//   returned to the video path.
//
//   new_game       master->slave  pulse; clears score and pending work
//   clear_valid    master->slave  pulse; line-clear event
//   lines_cleared  master->slave  lines for clear_valid, legal 1..4
//   drop_valid     master->slave  pulse; one soft-drop step (1 point)
//   score_digits   slave->master  committed packed-BCD score, 6 digits
//   busy           slave->master  adder is working on an addition
//   clear_overrun  slave->master  sticky; a clear request was lost
// ---------------------------------------------------------------------------
interface score_keeper_if;
    logic        new_game;
    logic        clear_valid;
    logic [2:0]  lines_cleared;
    logic        drop_valid;
    logic [23:0] score_digits;
    logic        busy;
    logic        clear_overrun;

    modport master (
        output new_game, clear_valid, lines_cleared, drop_valid,
        input  score_digits, busy, clear_overrun
    );

    modport slave (
        input  new_game, clear_valid, lines_cleared, drop_valid,
        output score_digits, busy, clear_overrun
    );
endinterface

// File: rtl/score_keeper.sv
// ---------------------------------------------------------------------------
// score_keeper
//   Accumulates line-clear and soft-drop points into a 6-digit packed-BCD
//   score using a digit-serial BCD adder (one digit per clock). The visible
//   score is only updated when a full addition commits, so downstream logic
//   never sees a partially added value. Overflow commits SAT_VALUE.
//
//   Clk    in   system clock
//   Reset  in   synchronous, active-high reset
//   bus    slave modport of score_keeper_if (event pulses in, score out)
// ---------------------------------------------------------------------------
module score_keeper #(
    parameter logic [23:0] PTS_1     = 24'h000040,
    parameter logic [23:0] PTS_2     = 24'h000100,
    parameter logic [23:0] PTS_3     = 24'h000300,
    parameter logic [23:0] PTS_4     = 24'h001200,
    parameter logic [23:0] SAT_VALUE = 24'h999999
) (
    input  logic          Clk,
    input  logic          Reset,
    score_keeper_if.slave bus
);

    typedef enum logic {
        ST_IDLE,
        ST_ADD
    } state_t;

    state_t      r_state;
    logic [23:0] r_score;
    logic [23:0] r_work;
    logic [23:0] r_addend;
    logic [23:0] r_clr_addend;
    logic        r_clr_pend;
    logic [3:0]  r_drop_cnt;
    logic [2:0]  r_idx;
    logic        r_carry;
    logic        r_busy;
    logic        r_overrun;

    logic        w_clr_legal;
    logic [23:0] w_clr_pts;
    logic        w_take_clr;
    logic        w_take_drop;
    logic [23:0] w_drop_bcd;
    logic [4:0]  w_bit_ofs;
    logic [3:0]  w_work_dig;
    logic [3:0]  w_add_dig;
    logic [4:0]  w_sum;
    logic        w_carry_out;
    logic [3:0]  w_dig_out;
    logic [23:0] w_work_next;

    // Points for the requested line count; illegal counts never get latched.
    always_comb begin
        w_clr_pts   = '0;
        w_clr_legal = 1'b0;
        case (bus.lines_cleared)
            3'd1: begin w_clr_pts = PTS_1; w_clr_legal = bus.clear_valid; end
            3'd2: begin w_clr_pts = PTS_2; w_clr_legal = bus.clear_valid; end
            3'd3: begin w_clr_pts = PTS_3; w_clr_legal = bus.clear_valid; end
            3'd4: begin w_clr_pts = PTS_4; w_clr_legal = bus.clear_valid; end
            default: begin w_clr_pts = '0; w_clr_legal = 1'b0; end
        endcase
    end

    // A pending slot is emptied on the edge the idle FSM starts an add from
    // it; clear always wins over drop.
    assign w_take_clr  = (r_state == ST_IDLE) && r_clr_pend;
    assign w_take_drop = (r_state == ST_IDLE) && !r_clr_pend && (r_drop_cnt != '0);

    // Binary 0..15 to two BCD digits.
    assign w_drop_bcd = (r_drop_cnt >= 4'd10) ? {16'h0000, 4'd1, r_drop_cnt - 4'd10}
                                              : {20'h00000, r_drop_cnt};

    // One BCD digit slice per clock, selected by r_idx.
    assign w_bit_ofs   = {r_idx, 2'b00};
    assign w_work_dig  = r_work[w_bit_ofs +: 4];
    assign w_add_dig   = r_addend[w_bit_ofs +: 4];
    assign w_sum       = {1'b0, w_work_dig} + {1'b0, w_add_dig} + {4'b0000, r_carry};
    assign w_carry_out = (w_sum > 5'd9);
    assign w_dig_out   = w_carry_out ? 4'(w_sum - 5'd10) : w_sum[3:0];

    always_comb begin
        w_work_next = r_work;
        w_work_next[w_bit_ofs +: 4] = w_dig_out;
    end

    always_ff @(posedge Clk) begin
        if (Reset || bus.new_game) begin
            // new_game aborts any add in flight without committing it.
            r_state      <= ST_IDLE;
            r_score      <= '0;
            r_work       <= '0;
            r_addend     <= '0;
            r_clr_addend <= '0;
            r_clr_pend   <= 1'b0;
            r_drop_cnt   <= '0;
            r_idx        <= '0;
            r_carry      <= 1'b0;
            r_busy       <= 1'b0;
            if (Reset) begin
                r_overrun <= 1'b0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take_clr) begin
                        r_addend <= r_clr_addend;
                        r_work   <= r_score;
                        r_idx    <= '0;
                        r_carry  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_ADD;
                    end else if (w_take_drop) begin
                        r_addend <= w_drop_bcd;
                        r_work   <= r_score;
                        r_idx    <= '0;
                        r_carry  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    r_work  <= w_work_next;
                    r_carry <= w_carry_out;
                    r_idx   <= r_idx + 3'd1;
                    if (r_idx == 3'd5) begin
                        // Final carry out of the top digit means overflow.
                        r_score <= w_carry_out ? SAT_VALUE : w_work_next;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Clear slot: a request arriving as the slot is consumed refills it.
            if (w_clr_legal) begin
                if (r_clr_pend && !w_take_clr) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_clr_pend   <= 1'b1;
                    r_clr_addend <= w_clr_pts;
                end
            end else if (w_take_clr) begin
                r_clr_pend <= 1'b0;
            end

            // Drop counter: reloads to 1 if a step lands on the consume edge.
            if (w_take_drop) begin
                r_drop_cnt <= bus.drop_valid ? 4'd1 : 4'd0;
            end else if (bus.drop_valid && (r_drop_cnt != 4'hF)) begin
                r_drop_cnt <= r_drop_cnt + 4'd1;
            end
        end
    end

    assign bus.score_digits  = r_score;
    assign bus.busy          = r_busy;
    assign bus.clear_overrun = r_overrun;

endmodule
